turn_crossing: RTL

Manoeuvre sequencer that takes over the motors when the line-following controller reports a crossing to be turned. It runs on the controller's 4-phase handshake: start in via `turn_crossing_start`, completion out via `line_follower_start`. The controller raises `turn_crossing_start` and waits. This block then does four things:
- drives the robot clear of the crossing;
- spins in the commanded direction until the middle sensor reacquires the line;
- reports completion;
- hands control back.

Its motor outputs feed the same motor drivers as the controller, via the top-level mux selected by `busy`.

---
 rtl/turn_crossing.sv | 127 ++++++++++++
 1 files changed

// File: rtl/turn_crossing.sv
// Crossing-turn manoeuvre sequencer: drives clear of a crossing, spins until the middle
// sensor reacquires the line, then hands the motors back over a 4-phase handshake.
module turn_crossing #(
   parameter int PERIOD_CYCLES    = 2_000_000,
   parameter int EXIT_PERIODS     = 10,
   parameter int MAX_TURN_PERIODS = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       turn_crossing_start,
   input  logic [1:0] turn_dir,
   input  logic       sensor_l,
   input  logic       sensor_m,
   input  logic       sensor_r,
   output logic       line_follower_start,
   output logic       busy,
   output logic       turn_timeout,
   output logic       motor_l_reset,
   output logic       motor_l_direction,
   output logic       motor_r_reset,
   output logic       motor_r_direction
);

   typedef enum logic [2:0] {IDLE, EXIT, SPIN_OFF, SPIN_ON, DONE} state_t;

   localparam logic [3:0] MOT_STOP  = 4'b1010;
   localparam logic [3:0] MOT_FWD   = 4'b0100;
   localparam logic [3:0] MOT_LSPIN = 4'b0000;
   localparam logic [3:0] MOT_RSPIN = 4'b0101;

   state_t      state, state_next;
   logic [20:0] pcnt;
   logic [7:0]  prd, spn;
   logic [1:0]  dir_q, pass;
   logic [3:0]  motor;
   logic        pe, spin, budget_out, reacquire, complete, timeout_hit;
   logic        unused_sensors;

   // Side sensors are ported for future turn qualification only.
   assign unused_sensors = sensor_l ^ sensor_r;

   assign pe          = (pcnt == 21'(PERIOD_CYCLES - 1));
   assign spin        = (state == SPIN_OFF) || (state == SPIN_ON);
   assign budget_out  = (({1'b0, spn} + 9'd1) == 9'(MAX_TURN_PERIODS));
   assign reacquire   = (state == SPIN_ON) && pe && !sensor_m;
   assign complete    = reacquire && (pass == 2'd1);
   // A reacquisition that finishes the turn on the last budget period beats the timeout.
   assign timeout_hit = spin && pe && budget_out && !complete;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         pcnt         <= '0;
         prd          <= '0;
         spn          <= '0;
         dir_q        <= '0;
         pass         <= '0;
         turn_timeout <= 1'b0;
      end else begin
         state <= state_next;
         if ((state_next != state) || (state == IDLE) || pe)
            pcnt <= '0;
         else
            pcnt <= pcnt + 21'd1;

         case (state)
            IDLE: begin
               if (turn_crossing_start) begin
                  dir_q        <= turn_dir;
                  pass         <= (turn_dir == 2'b11) ? 2'd2 : 2'd1;
                  prd          <= '0;
                  spn          <= '0;
                  turn_timeout <= 1'b0;
               end
            end
            EXIT: begin
               if (pe) prd <= prd + 8'd1;
            end
            SPIN_OFF, SPIN_ON: begin
               if (pe)          spn          <= spn + 8'd1;
               if (reacquire)   pass         <= pass - 2'd1;
               if (timeout_hit) turn_timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (turn_crossing_start) state_next = EXIT;
         end
         EXIT: begin
            if (pe && (prd == 8'(EXIT_PERIODS - 1)))
               state_next = (dir_q == 2'b00) ? DONE : SPIN_OFF;
         end
         SPIN_OFF: begin
            if (timeout_hit)          state_next = DONE;
            else if (pe && sensor_m)  state_next = SPIN_ON;
         end
         SPIN_ON: begin
            if (complete || timeout_hit) state_next = DONE;
            else if (reacquire)          state_next = SPIN_OFF;
         end
         DONE: begin
            if (!turn_crossing_start) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy                = (state != IDLE);
      line_follower_start = (state == DONE);
      motor               = MOT_STOP;
      case (state)
         EXIT:              motor = MOT_FWD;
         SPIN_OFF, SPIN_ON: motor = (dir_q == 2'b10) ? MOT_RSPIN : MOT_LSPIN;
         default:           motor = MOT_STOP;
      endcase
   end

   assign {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} = motor;

endmodule
